// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: FSM states and scan-code prefixes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchronizer followed by a glitch filter for one raw PS/2 pin.
// The filtered level only follows the pin after FILTER_LEN equal samples.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    // NOTE: everything resets to 1 so a released bus looks idle and no false edge is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                level   <= sync2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: decodes 11-bit frames and folds E0/F0
// prefixes into the extended/key_release flags reported with each scan code.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       extended,
    output logic       key_release,
    output logic       got_code,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_f;
    logic          data_f;
    logic          clk_prev;
    logic          fall;

    ps2_state_t    state_q,    state_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    logic [7:0]    shift_q,    shift_d;
    logic          par_err_q,  par_err_d;
    logic          ext_q,      ext_d;
    logic          brk_q,      brk_d;
    logic [TW-1:0] tcnt_q,     tcnt_d;
    logic [7:0]    scan_d;
    logic          extended_d;
    logic          release_d;
    logic          got_d;
    logic          err_d;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_clk),
        .level   (clk_f)
    );

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_data),
        .level   (data_f)
    );

    assign fall = clk_prev & ~clk_f;

    // NOTE: every next-state value is defaulted first so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        tcnt_d     = tcnt_q;
        scan_d     = scan_code;
        extended_d = extended;
        release_d  = key_release;
        got_d      = 1'b0;
        err_d      = 1'b0;

        if (fall) begin
            tcnt_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_f) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        par_err_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_err_d = ~(^{shift_q, data_f});
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!data_f || par_err_q) begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else if (shift_q == PS2_EXT_PREFIX) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PS2_BRK_PREFIX) begin
                        brk_d = 1'b1;
                    end else begin
                        scan_d     = shift_q;
                        extended_d = ext_q;
                        release_d  = brk_q;
                        got_d      = 1'b1;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled frame is abandoned; an edge in the same cycle takes priority above.
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_err_q   <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            tcnt_q      <= '0;
            scan_code   <= 8'h00;
            extended    <= 1'b0;
            key_release <= 1'b0;
            got_code    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            clk_prev    <= clk_f;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            tcnt_q      <= tcnt_d;
            scan_code   <= scan_d;
            extended    <= extended_d;
            key_release <= release_d;
            got_code    <= got_d;
            frame_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: table of frames plus hand-written
// timeout, glitch and reset sequences, checked through a result scoreboard.
module tb_ps2_frame_rx;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 300;
    localparam int HALF       = 20;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       extended;
    logic       key_release;
    logic       got_code;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .extended    (extended),
        .key_release (key_release),
        .got_code    (got_code),
        .frame_err   (frame_err)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        logic       bad_stop;
        logic       has_exp;
        logic       exp_err;
        logic [7:0] exp_code;
        logic       exp_ext;
        logic       exp_rel;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_code(input logic [7:0] code, input logic ext, input logic rel);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = code;
        e.ext    = ext;
        e.rel    = rel;
        sb_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.code   = 8'h00;
        e.ext    = 1'b0;
        e.rel    = 1'b0;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every output pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && (got_code || frame_err)) begin
            check("got_err_exclusive", {31'd0, got_code & frame_err}, 32'd0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got_code=%b frame_err=%b code=%0h, nothing expected",
                         got_code, frame_err, scan_code);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_kind_err", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                if (!mon_e.is_err) begin
                    check("sb_code", {24'd0, scan_code}, {24'd0, mon_e.code});
                    check("sb_extended", {31'd0, extended}, {31'd0, mon_e.ext});
                    check("sb_release", {31'd0, key_release}, {31'd0, mon_e.rel});
                end
            end
        end
    end

    // Bits sent in order: start, d[0..7], parity, stop. Optional 2-cycle clock
    // glitch inside the high phase before bit glitch_bit falls.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                              input int glitch_bit, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            for (int c = 0; c < HALF; c++) begin
                @(negedge clk);
                if (i == glitch_bit && c == 8)  ps2_clk = 1'b0;
                if (i == glitch_bit && c == 10) ps2_clk = 1'b1;
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100 && sb_q.size() != 0; c++) @(negedge clk);
        check(name, sb_q.size(), 0);
    endtask

    logic [7:0] last_code;
    int         n;
    logic       seen;

    initial begin
        //            d      bpar  bstop has  err   code   ext   rel
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, 1'b1};
        vecs[4]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0};
        vecs[5]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[7]  = '{8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE1, 1'b0, 1'b0};
        vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h4B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[11] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_scan_code", {24'd0, scan_code}, 32'h00);
        check("rst_extended", {31'd0, extended}, 32'd0);
        check("rst_release", {31'd0, key_release}, 32'd0);
        check("rst_got_code", {31'd0, got_code}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Table of frames
        last_code = 8'h00;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].has_exp) begin
                if (vecs[i].exp_err) expect_err();
                else expect_code(vecs[i].exp_code, vecs[i].exp_ext, vecs[i].exp_rel);
            end
            send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop, -1, 11);
            drain($sformatf("drain_vec%0d", i));
            if (vecs[i].has_exp && vecs[i].exp_err)
                check($sformatf("held_code_vec%0d", i), {24'd0, scan_code}, {24'd0, last_code});
            if (vecs[i].has_exp && !vecs[i].exp_err)
                last_code = vecs[i].exp_code;
        end

        // Timeout: E0 prefix, then start + 4 data bits and silence
        send_frame(8'hE0, 1'b0, 1'b0, -1, 11);
        expect_err();
        send_frame(8'hA5, 1'b0, 1'b0, -1, 4);
        @(negedge clk);
        ps2_data = 1'b0;   // bit 3 of A5
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < TIMEOUT + 200) begin
            @(negedge clk);
            n++;
            if (n == HALF) begin
                ps2_clk  = 1'b1;
                ps2_data = 1'b1;
            end
            if (frame_err) seen = 1'b1;
        end
        check("timeout_latency", n, FILTER_LEN + 3 + TIMEOUT);
        repeat (5) @(negedge clk);
        drain("drain_timeout");
        expect_code(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, -1, 11);
        send_frame(8'h1C, 1'b0, 1'b0, -1, 11);
        drain("drain_after_timeout");

        // Glitches: idle glitch with data low, then a glitch mid-DATA
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        expect_code(8'h6B, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0, 4, 11);
        drain("drain_glitch");

        // Reset mid-frame: start + 5 data bits, then reset_n low
        send_frame(8'h3D, 1'b0, 1'b0, -1, 6);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_scan_code", {24'd0, scan_code}, 32'h00);
        check("midrst_extended", {31'd0, extended}, 32'd0);
        check("midrst_release", {31'd0, key_release}, 32'd0);
        check("midrst_got_code", {31'd0, got_code}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        expect_code(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0, -1, 11);
        drain("drain_after_reset");
        check("final_scan_code", {24'd0, scan_code}, 32'h29);

        repeat (10) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive equal samples needed to accept a new ps2_clk/ps2_data level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000 (2 ms at 25 MHz): maximum clk cycles between falling ps2_clk edges inside a frame.
REQ-003 SHALL have port clk, input, 1: single system clock (25 MHz main clock); all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk, input, 1: raw PS/2 clock pin, asynchronous.
REQ-006 SHALL have port ps2_data, input, 1: raw PS/2 data pin, asynchronous.
REQ-007 SHALL have port scan_code, output, 8: last non-prefix scan code, held until the next valid.
REQ-008 SHALL have port extended, output, 1: E0 prefix preceded scan_code.
REQ-009 SHALL have port release, output, 1: F0 prefix preceded scan_code (key break).
REQ-010 SHALL have port got_code, output, 1: one-cycle pulse when scan_code/extended/release update.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on a framing, parity or timeout error.

Function
REQ-012 SHALL pass each pin through a 2-flop synchronizer, then a filter that changes level only after FILTER_LEN consecutive identical synchronized samples.
REQ-013 SHALL detect a falling edge as filtered ps2_clk going 1->0; all bit sampling uses filtered ps2_data in that edge cycle.
REQ-014 SHALL implement FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing one state per edge; DATA spans 8 edges.
REQ-015 SHALL, in IDLE, accept an edge with data=0 as the start bit and enter DATA; an edge with data=1 keeps IDLE without error.
REQ-016 SHALL shift data bits LSB first into an 8-bit register, using a 3-bit bit counter that wraps 7->0 on the exit to PARITY.
REQ-017 SHALL check odd parity over 8 data bits plus the parity bit; a mismatch is recorded and reported at STOP.
REQ-018 SHALL require stop bit=1; stop=0 or recorded parity error -> frame_err pulse, byte discarded, return to IDLE.
REQ-019 SHALL handle a good byte of 8'hE0 by setting the ext flag, 8'hF0 by setting the brk flag, with no got_code.
REQ-020 SHALL handle any other good byte (including 8'hE1) by loading scan_code, copying ext->extended and brk->release, pulsing got_code one cycle after the stop-bit edge, and clearing ext and brk in the same cycle.
REQ-021 SHALL reset a timeout counter on every falling edge, count only outside IDLE, and on reaching TIMEOUT_CYCLES pulse frame_err, clear ext/brk and force IDLE.
REQ-022 SHALL clear ext/brk on any frame_err.
REQ-023 SHALL let a timeout and an edge in the same cycle resolve with the edge winning (counter clears, no error).
REQ-024 SHALL never assert got_code and frame_err in the same cycle.

Reset
REQ-025 SHALL asynchronously force, on reset_n=0: FSM IDLE; scan_code=8'h00; extended, release, got_code and frame_err =0; ext/brk flags, bit counter and timeout counter =0; synchronizers and filters =1 (bus idle).
REQ-026 SHALL abandon a frame interrupted by reset without emitting it; reception resumes at the next start bit after release.

Structure
REQ-027 SHALL take the FSM state enum and constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0 from shared package ps2_pkg.
REQ-028 SHALL implement synchronizer+filter as sub-module ps2_input_filter (parameter FILTER_LEN), instantiated once per pin.

Verification
REQ-029 SHALL cover: frame for 8'h1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> got_code one pulse, scan_code=8'h1C, extended=0, release=0.
REQ-030 SHALL cover: frames E0, F0, 75 -> only one got_code, scan_code=8'h75, extended=1, release=1; a following 8'h1C frame -> extended=0, release=0.
REQ-031 SHALL cover: 8'h1C with parity bit 1 -> frame_err one pulse, no got_code, scan_code unchanged; the next good frame is received.
REQ-032 SHALL cover: start plus 4 data bits then idle -> frame_err exactly TIMEOUT_CYCLES cycles after the last edge; a following F0, 1C sequence -> release=1, extended=0.
REQ-033 SHALL cover: a 2-cycle low glitch on ps2_clk in IDLE and mid-DATA -> no edge counted, frame decodes correctly.
REQ-034 SHALL cover: reset_n pulsed low after 5 data bits -> outputs at reset values immediately, no got_code; the next full frame 8'h29 -> scan_code=8'h29.
